// File: rtl/hazard_controller_if.sv
// -----------------------------------------------------------------------------
// hazard_controller_if
//   Bundles every pipeline-facing signal of the hazard controller.
//   The pipeline datapath uses the master modport: it drives the register
//   indices, write enables and memory handshake, and receives the stall,
//   flush and forward controls. The hazard controller uses the slave modport.
//
//   Pipeline -> controller:
//     Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW   register indices (5 bits)
//     RegWriteM, RegWriteW, LoadE, PCSrcE     instruction attributes
//     MemReqM, MemReadyM                      data-memory handshake
//   Controller -> pipeline:
//     StallF, StallD, StallE, StallM          hold PC / pipeline registers
//     FlushD, FlushE, FlushW                  bubble into ID, EX, WB
//     ForwardAE, ForwardBE                    EX operand mux selects
//     MemErr                                  sticky memory-timeout flag
//     PerfLwStall, PerfFlush, PerfMemStall    only with HAZARD_PERF_CNT_EN
// -----------------------------------------------------------------------------
interface hazard_controller_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [4:0]  RdM;
  logic [4:0]  RdW;
  logic        RegWriteM;
  logic        RegWriteW;
  logic        LoadE;
  logic        PCSrcE;
  logic        MemReqM;
  logic        MemReadyM;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        StallM;
  logic        FlushD;
  logic        FlushE;
  logic        FlushW;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        MemErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] PerfLwStall;
  logic [31:0] PerfFlush;
  logic [31:0] PerfMemStall;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemErr,
    input  PerfLwStall, PerfFlush, PerfMemStall
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemErr,
    output PerfLwStall, PerfFlush, PerfMemStall
  );
`else
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemErr
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemErr
  );
`endif
endinterface

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Central hazard / sequencing unit of the 5-stage RV32 pipeline.
//   - EX-stage operand forwarding (M result has priority over W result).
//   - Load-use stall of IF/ID with a bubble into EX.
//   - Taken branch / jump flush of ID and EX.
//   - Multi-cycle data-memory waits freeze the whole pipeline; a wait that
//     lasts MEM_TIMEOUT stall cycles is abandoned: one RELEASE cycle kills
//     the WB result and sets the sticky MemErr flag.
//
// Parameters:
//   MEM_TIMEOUT  max stall cycles per memory access (2..255)
//   CNT_W        width of the wait counter (must hold MEM_TIMEOUT)
//
// Ports:
//   clk  pipeline clock
//   rst  synchronous active-high reset
//   hz   hazard_controller_if.slave, all pipeline-facing signals
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   Adds saturating 32-bit counters PerfLwStall, PerfFlush, PerfMemStall.
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  hazard_controller_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_WAIT    = 2'b01,
    ST_RELEASE = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  // Forward select for one EX source operand: M beats W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_s;
  logic             mem_err_r;

  logic             lw_stall_s;
  logic             mem_stall_s;
  logic             in_release_s;

  logic             stall_f_s;
  logic             stall_d_s;
  logic             stall_e_s;
  logic             stall_m_s;
  logic             flush_d_s;
  logic             flush_e_s;
  logic             flush_w_s;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;

  // Hazard detection terms.
  always_comb begin
    in_release_s = (state_r == ST_RELEASE);
    lw_stall_s   = hz.LoadE && (hz.RdE != 5'd0) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    // The RELEASE cycle ignores the still-pending request so the pipeline moves.
    mem_stall_s  = hz.MemReqM && !hz.MemReadyM && !in_release_s;
  end

  // Forwarding muxes, purely combinational and independent of reset.
  always_comb begin
    fwd_a_s = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    fwd_b_s = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  end

  // Stall / flush generation with priority memStall > PCSrcE > lwStall.
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    flush_w_s = 1'b0;
    if (rst) begin
      stall_f_s = 1'b0;
      flush_w_s = 1'b0;
    end else if (mem_stall_s) begin
      // Freeze everything; a held ID/EX must not also be flushed, the branch
      // or load hazard is re-evaluated once memory completes.
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
      flush_w_s = 1'b1;
    end else begin
      stall_f_s = lw_stall_s && !in_release_s;
      stall_d_s = lw_stall_s && !in_release_s;
      flush_d_s = hz.PCSrcE;
      flush_e_s = hz.PCSrcE || lw_stall_s;
      flush_w_s = in_release_s;
    end
  end

  // Memory-wait FSM next state and wait counter.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (mem_stall_s) begin
          state_s    = ST_WAIT;
          wait_cnt_s = CNT_ONE;
        end else begin
          state_s    = ST_RUN;
          wait_cnt_s = CNT_ZERO;
        end
      end
      ST_WAIT: begin
        if (hz.MemReadyM) begin
          state_s    = ST_RUN;
          wait_cnt_s = CNT_ZERO;
        end else if (wait_cnt_r == CNT_LAST) begin
          state_s    = ST_RELEASE;
          wait_cnt_s = CNT_ZERO;
        end else begin
          state_s    = ST_WAIT;
          wait_cnt_s = wait_cnt_r + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        state_s    = ST_RUN;
        wait_cnt_s = CNT_ZERO;
      end
      default: begin
        state_s    = ST_RUN;
        wait_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= CNT_ZERO;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Sticky timeout flag, set by the RELEASE cycle, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err_r <= 1'b0;
    end else if (state_r == ST_RELEASE) begin
      mem_err_r <= 1'b1;
    end else begin
      mem_err_r <= mem_err_r;
    end
  end

  assign hz.StallF    = stall_f_s;
  assign hz.StallD    = stall_d_s;
  assign hz.StallE    = stall_e_s;
  assign hz.StallM    = stall_m_s;
  assign hz.FlushD    = flush_d_s;
  assign hz.FlushE    = flush_e_s;
  assign hz.FlushW    = flush_w_s;
  assign hz.ForwardAE = fwd_a_s;
  assign hz.ForwardBE = fwd_b_s;
  assign hz.MemErr    = mem_err_r;

`ifdef HAZARD_PERF_CNT_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    logic [31:0] res;
    if (val == 32'hFFFF_FFFF) begin
      res = val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

  logic [31:0] perf_lw_r;
  logic [31:0] perf_flush_r;
  logic [31:0] perf_mem_r;

  // Performance counters; events hidden behind a memory stall are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lw_r    <= 32'd0;
      perf_flush_r <= 32'd0;
      perf_mem_r   <= 32'd0;
    end else begin
      perf_lw_r    <= (lw_stall_s && !mem_stall_s) ? sat_inc(perf_lw_r) : perf_lw_r;
      perf_flush_r <= (hz.PCSrcE && !mem_stall_s) ? sat_inc(perf_flush_r) : perf_flush_r;
      perf_mem_r   <= mem_stall_s ? sat_inc(perf_mem_r) : perf_mem_r;
    end
  end

  assign hz.PerfLwStall  = perf_lw_r;
  assign hz.PerfFlush    = perf_flush_r;
  assign hz.PerfMemStall = perf_mem_r;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//   Directed scenarios followed by randomized traffic, all checked against a
//   cycle-level reference model that tracks how many consecutive stall cycles
//   the current memory access has consumed.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

  localparam int T = 4;

  logic clk;
  logic rst;

  hazard_controller_if hz ();

  hazard_controller #(
    .MEM_TIMEOUT (T),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int          m_stalled = 0;
  bit          m_rel     = 1'b0;
  bit          m_err     = 1'b0;
  logic [31:0] m_p_lw    = 32'd0;
  logic [31:0] m_p_fl    = 32'd0;
  logic [31:0] m_p_ms    = 32'd0;

  // Random memory-op generator state.
  bit op_active = 1'b0;
  int op_lat    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock: check outputs at the negedge, then advance the model past the posedge.
  task automatic step();
    bit lw;
    bit ms;
    logic [3:0] e_stall;
    logic [2:0] e_flush;
    @(negedge clk);
    #1;
    lw = hz.LoadE && hz.RdE != 5'd0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    ms = hz.MemReqM && !hz.MemReadyM && !m_rel;
    if (rst) begin
      e_stall = 4'b0000;
      e_flush = 3'b000;
    end else if (ms) begin
      e_stall = 4'b1111;
      e_flush = 3'b001;
    end else begin
      e_stall = {lw && !m_rel, lw && !m_rel, 1'b0, 1'b0};
      e_flush = {hz.PCSrcE, hz.PCSrcE || lw, m_rel};
    end
    check_val("stall", {28'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM}, {28'd0, e_stall});
    check_val("flush", {29'd0, hz.FlushD, hz.FlushE, hz.FlushW}, {29'd0, e_flush});
    check_val("fwdA", {30'd0, hz.ForwardAE}, {30'd0, ref_fwd(hz.Rs1E)});
    check_val("fwdB", {30'd0, hz.ForwardBE}, {30'd0, ref_fwd(hz.Rs2E)});
    check_val("memerr", {31'd0, hz.MemErr}, {31'd0, m_err});
`ifdef HAZARD_PERF_CNT_EN
    check_val("perf_lw", hz.PerfLwStall, m_p_lw);
    check_val("perf_flush", hz.PerfFlush, m_p_fl);
    check_val("perf_mem", hz.PerfMemStall, m_p_ms);
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      m_stalled = 0;
      m_rel     = 1'b0;
      m_err     = 1'b0;
      m_p_lw    = 32'd0;
      m_p_fl    = 32'd0;
      m_p_ms    = 32'd0;
    end else begin
      if (lw && !ms)        m_p_lw = sat1(m_p_lw);
      if (hz.PCSrcE && !ms) m_p_fl = sat1(m_p_fl);
      if (ms)               m_p_ms = sat1(m_p_ms);
      if (m_rel) begin
        m_err     = 1'b1;
        m_rel     = 1'b0;
        m_stalled = 0;
      end else if (ms) begin
        m_stalled++;
        if (m_stalled == T) begin
          m_rel     = 1'b1;
          m_stalled = 0;
        end
      end else begin
        m_stalled = 0;
      end
    end
  endtask

  task automatic clear_inputs();
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
    hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.LoadE = 1'b0;
    hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  task automatic rand_cycle();
    rst = ($urandom_range(0, 63) == 0);
    hz.Rs1D = 5'($urandom_range(0, 7)); hz.Rs2D = 5'($urandom_range(0, 7));
    hz.Rs1E = 5'($urandom_range(0, 7)); hz.Rs2E = 5'($urandom_range(0, 7));
    hz.RdE  = 5'($urandom_range(0, 7)); hz.RdM  = 5'($urandom_range(0, 7));
    hz.RdW  = 5'($urandom_range(0, 7));
    hz.RegWriteM = 1'($urandom_range(0, 1));
    hz.RegWriteW = 1'($urandom_range(0, 1));
    hz.LoadE     = 1'($urandom_range(0, 1));
    hz.PCSrcE    = ($urandom_range(0, 3) == 0);
    if (!op_active && $urandom_range(0, 3) == 0) begin
      op_active = 1'b1;
      op_lat    = $urandom_range(0, 6);
    end
    if (op_active) begin
      hz.MemReqM = 1'b1;
      if (m_rel) begin
        hz.MemReadyM = 1'($urandom_range(0, 1));
        op_active    = 1'b0;
      end else if (op_lat == 0) begin
        hz.MemReadyM = 1'b1;
        op_active    = 1'b0;
      end else begin
        hz.MemReadyM = 1'b0;
        op_lat--;
      end
    end else begin
      hz.MemReqM   = 1'b0;
      hz.MemReadyM = 1'($urandom_range(0, 1));
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    #1;
    check_val("reset_memerr", {31'd0, hz.MemErr}, 32'd0);
    check_val("reset_stallf", {31'd0, hz.StallF}, 32'd0);

    // Forwarding precedence.
    hz.RdM = 5'd5; hz.RdW = 5'd5; hz.Rs1E = 5'd5;
    hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
    #1 check_val("fwd_m_prio", {30'd0, hz.ForwardAE}, 32'd2);
    hz.RegWriteM = 1'b0;
    #1 check_val("fwd_w", {30'd0, hz.ForwardAE}, 32'd1);
    hz.RegWriteM = 1'b1; hz.Rs1E = 5'd0; hz.RdM = 5'd0;
    #1 check_val("fwd_x0", {30'd0, hz.ForwardAE}, 32'd0);
    step();

    // Load-use for one cycle, then x0 destination.
    clear_inputs();
    hz.LoadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    #1 check_val("lw_stallf", {30'd0, hz.StallF, hz.StallD}, 32'd3);
    check_val("lw_flush", {30'd0, hz.FlushD, hz.FlushE}, 32'd1);
    step();
    hz.LoadE = 1'b0;
    #1 check_val("lw_done", {30'd0, hz.StallF, hz.FlushE}, 32'd0);
    step();
    hz.LoadE = 1'b1; hz.RdE = 5'd0; hz.Rs2D = 5'd0;
    #1 check_val("lw_x0", {30'd0, hz.StallF, hz.FlushE}, 32'd0);
    step();

    // Branch together with load-use.
    hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.PCSrcE = 1'b1;
    #1 check_val("br_lw", {29'd0, hz.FlushD, hz.FlushE, hz.StallF}, 32'd7);
    step();

    // Memory wait of 3 cycles with a pending branch.
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check_val("mw_stall", {28'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM}, 32'hF);
      check_val("mw_flush", {29'd0, hz.FlushD, hz.FlushE, hz.FlushW}, 32'd1);
      step();
    end
    hz.MemReadyM = 1'b1;
    #1 check_val("mw_ready", {31'd0, hz.StallM}, 32'd0);
    step();
    clear_inputs();
    #1 check_val("mw_memerr", {31'd0, hz.MemErr}, 32'd0);

    // Timeout: T stall cycles, one release cycle, sticky error.
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int i = 0; i < T; i++) begin
      #1 check_val("to_stall", {31'd0, hz.StallM}, 32'd1);
      step();
    end
    #1 check_val("to_release", {28'd0, hz.StallF, hz.StallE, hz.StallM, hz.FlushW}, 32'd1);
    step();
    hz.MemReqM = 1'b0;
    #1 check_val("to_memerr", {31'd0, hz.MemErr}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    #1 check_val("to_sticky", {31'd0, hz.MemErr}, 32'd1);

    // Reset in the middle of a wait, then a fresh full-length wait.
    hz.MemReqM = 1'b1;
    step();
    rst = 1'b1;
    #1 check_val("rst_gate", {31'd0, hz.StallF}, 32'd0);
    step();
    rst = 1'b0;
    #1 check_val("rst_memerr", {31'd0, hz.MemErr}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check_val("rst_perf", hz.PerfLwStall | hz.PerfFlush | hz.PerfMemStall, 32'd0);
`endif
    for (int i = 0; i < T; i++) begin
      #1 check_val("rst_fresh", {31'd0, hz.StallM}, 32'd1);
      step();
    end
    step();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) rand_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
